mem32_port_arbiter: RTL and testbench

//  Shares the single read/write port pair of the 32-bit memory model between NUM_REQ requesters (harts or fetch/LSU).

---
 rtl/mem32_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem32_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem32_port_arbiter.sv
// mem32_port_arbiter
// Round-robin arbiter sharing one 32-bit memory read/write port pair between
// NUM_REQ requesters. One transaction is in flight at a time; byte-enabled
// stores are done as read-modify-write because the memory writes whole words.
module mem32_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0] req_be,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_error,
  output logic [ADDR_W-1:0]    mem_read_address,
  input  logic [31:0]          mem_read_data,
  input  logic                 mem_read_exception,
  output logic                 mem_write_enable,
  output logic [ADDR_W-1:0]    mem_write_address,
  output logic [31:0]          mem_write_data,
  input  logic                 mem_write_exception
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RSP    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_found;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [3:0]        be_q, be_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [31:0]       merged_word;

  // Round-robin search: first valid requester at or above rr_ptr, with wrap.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  // Read-modify-write merge: enabled bytes from the store, the rest from memory.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      merged_word[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : buf_q[8*k +: 8];
    end
  end

  // Next-state, datapath capture and all outputs of the transaction FSM.
  always_comb begin
    // NOTE: every output and next-value gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    owner_d           = owner_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    be_d              = be_q;
    write_d           = write_q;
    buf_d             = buf_q;
    err_d             = err_q;
    req_ready         = '0;
    rsp_valid         = '0;
    rsp_data          = '0;
    rsp_error         = 1'b0;
    mem_read_address  = '0;
    mem_write_enable  = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          owner_d  = grant_idx;
          addr_d   = req_addr[32*int'(grant_idx) +: 32];
          wdata_d  = req_wdata[32*int'(grant_idx) +: 32];
          be_d     = req_be[4*int'(grant_idx) +: 4];
          write_d  = req_write[grant_idx];
          buf_d    = '0;
          err_d    = 1'b0;
          state_d  = ACCESS;
        end
      end

      ACCESS: begin
        state_d = RSP;
        if (addr_q[1:0] != 2'b00) begin
          // Misaligned: never touch memory.
          err_d = 1'b1;
        end else if (write_q && be_q == 4'h0) begin
          // Store with no bytes enabled is a no-op.
          err_d = 1'b0;
        end else if (write_q && be_q == 4'hF) begin
          mem_read_address  = ADDR_W'(addr_q);
          mem_write_enable  = 1'b1;
          mem_write_address = ADDR_W'(addr_q);
          mem_write_data    = wdata_q;
          err_d             = mem_write_exception;
        end else begin
          // Load, or first half of a partial store.
          mem_read_address = ADDR_W'(addr_q);
          buf_d            = mem_read_data;
          err_d            = mem_read_exception;
          if (write_q && !mem_read_exception) state_d = WRITE;
        end
      end

      WRITE: begin
        mem_write_enable  = 1'b1;
        mem_write_address = ADDR_W'(addr_q);
        mem_write_data    = merged_word;
        err_d             = mem_write_exception;
        state_d           = RSP;
      end

      RSP: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_data           = write_q ? 32'h0 : buf_q;
        rsp_error          = err_q;
        if (rsp_ready[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RESET) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
      buf_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      write_q  <= write_d;
      buf_q    <= buf_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem32_port_arbiter.sv
// tb_mem32_port_arbiter
// Directed scenarios plus randomized traffic against a transaction-level model
// of the arbiter (round-robin grant, expected latency, response and memory image).
module tb_mem32_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic [NUM_REQ-1:0]    req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [NUM_REQ*32-1:0] req_addr, req_wdata;
  logic [NUM_REQ*4-1:0]  req_be;
  logic [31:0]           rsp_data;
  logic                  rsp_error;
  logic [ADDR_W-1:0]     mem_read_address, mem_write_address;
  logic [31:0]           mem_read_data, mem_write_data;
  logic                  mem_read_exception, mem_write_exception, mem_write_enable;

  always #5 CLK = ~CLK;

  mem32_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .req_be              (req_be),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .rsp_error           (rsp_error),
    .mem_read_address    (mem_read_address),
    .mem_read_data       (mem_read_data),
    .mem_read_exception  (mem_read_exception),
    .mem_write_enable    (mem_write_enable),
    .mem_write_address   (mem_write_address),
    .mem_write_data      (mem_write_data),
    .mem_write_exception (mem_write_exception)
  );

  // Memory model: 16 words at 0x80000000, combinational read, no write on exception.
  logic [31:0]      dut_mem [16];
  logic [31:0]      ref_mem [16];
  int               wr_count = 0;
  logic             pl_en = 1'b0;
  logic [3:0]       pl_idx = '0;
  logic [31:0]      pl_val = '0;

  assign mem_read_data = dut_mem[mem_read_address[5:2]];

  always @(posedge CLK) begin
    if (pl_en) begin
      dut_mem[pl_idx] <= pl_val;
    end else if (mem_write_enable) begin
      wr_count <= wr_count + 1;
      if (!mem_write_exception) dut_mem[mem_write_address[5:2]] <= mem_write_data;
    end
  end

  // Pending request per requester, held on the bus until granted.
  bit          p_valid [NUM_REQ];
  logic        p_write [NUM_REQ];
  logic [31:0] p_addr  [NUM_REQ];
  logic [31:0] p_wdata [NUM_REQ];
  logic [3:0]  p_be    [NUM_REQ];
  int          rr;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NUM_REQ; r++) begin
      req_valid[r]           = p_valid[r];
      req_write[r]           = p_write[r];
      req_addr[32*r +: 32]   = p_addr[r];
      req_wdata[32*r +: 32]  = p_wdata[r];
      req_be[4*r +: 4]       = p_be[r];
    end
  endtask

  task automatic set_req(input int r, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    p_valid[r] = 1'b1;
    p_write[r] = wr;
    p_addr[r]  = a;
    p_wdata[r] = wd;
    p_be[r]    = be;
    drive();
  endtask

  task automatic preload(input int i, input logic [31:0] v);
    pl_en  = 1'b1;
    pl_idx = 4'(i);
    pl_val = v;
    ref_mem[i] = v;
    @(posedge CLK); #1;
    pl_en = 1'b0;
  endtask

  // Expected grant from the pending set: first valid at or above rr, with wrap.
  function automatic int model_grant();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (p_valid[(rr + i) % NUM_REQ]) return (rr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  // One arbitration slot: checks grant, latency, memory traffic and response.
  task automatic serve(input int hold, input bit poke_other, output int g_out);
    int g, lat, we_cyc, idx, wc0;
    logic wr, mis, exp_err, chk_data;
    logic [31:0] a, wd, exp_data, new_word;
    logic [3:0] be;
    g = model_grant();
    g_out = g;
    @(negedge CLK);
    check("grant", 32'(req_ready), (g < 0) ? 32'h0 : (32'h1 << g));
    if (g < 0) begin
      @(posedge CLK); #1;
      return;
    end
    wr = p_write[g]; a = p_addr[g]; wd = p_wdata[g]; be = p_be[g];
    @(posedge CLK); #1;
    p_valid[g] = 1'b0;
    drive();
    wc0 = wr_count;
    idx = int'(a[5:2]);
    mis = (a[1:0] != 2'b00);
    for (int k = 0; k < 4; k++) new_word[8*k +: 8] = be[k] ? wd[8*k +: 8] : ref_mem[idx][8*k +: 8];
    lat = 2; we_cyc = 0;
    if (mis)                      exp_err = 1'b1;
    else if (wr && be == 4'h0)    exp_err = 1'b0;
    else if (wr && be == 4'hF)    begin exp_err = mem_write_exception; we_cyc = 1; end
    else if (!wr)                 exp_err = mem_read_exception;
    else if (mem_read_exception)  exp_err = 1'b1;
    else                          begin exp_err = mem_write_exception; we_cyc = 2; lat = 3; end
    exp_data = wr ? 32'h0 : ref_mem[idx];
    chk_data = !(mis && !wr);
    for (int c = 1; c < lat; c++) begin
      @(negedge CLK);
      check("busy_rsp_valid", 32'(rsp_valid), 32'h0);
      check("busy_req_ready", 32'(req_ready), 32'h0);
      check("wr_en_timing", 32'(mem_write_enable), 32'(c == we_cyc));
      if (c == we_cyc) begin
        check("wr_addr", mem_write_address, a);
        check("wr_data", mem_write_data, new_word);
      end
      @(posedge CLK); #1;
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge CLK);
      check("rsp_valid", 32'(rsp_valid), 32'h1 << g);
      check("rsp_error", 32'(rsp_error), 32'(exp_err));
      if (chk_data) check("rsp_data", rsp_data, exp_data);
      check("rsp_req_ready", 32'(req_ready), 32'h0);
      check("rsp_wr_en", 32'(mem_write_enable), 32'h0);
      if (h == hold) rsp_ready[g] = 1'b1;
      else if (poke_other) rsp_ready[(g + 1) % NUM_REQ] = 1'b1;
      @(posedge CLK); #1;
      rsp_ready = '0;
    end
    check("write_count", 32'(wr_count - wc0), 32'(we_cyc != 0));
    if (we_cyc != 0 && !mem_write_exception) ref_mem[idx] = new_word;
    check("mem_word", dut_mem[idx], ref_mem[idx]);
    rr = (g + 1) % NUM_REQ;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  function automatic logic [3:0] rand_be();
    case ($urandom_range(0, 3))
      0:       return 4'hF;
      1:       return 4'h0;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    int g, prev_g, wc;
    RESET = 1'b1;
    rsp_ready = '0;
    mem_read_exception = 1'b0;
    mem_write_exception = 1'b0;
    rr = 0;
    for (int r = 0; r < NUM_REQ; r++) begin
      p_valid[r] = 1'b0; p_write[r] = 1'b0; p_addr[r] = '0; p_wdata[r] = '0; p_be[r] = '0;
    end
    drive();
    for (int i = 0; i < 16; i++) begin
      preload(i, (i == 4) ? 32'hDEAD_BEEF : (i == 8) ? 32'h1122_3344 : $urandom);
    end

    // Reset state
    @(negedge CLK);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_error", 32'(rsp_error), 32'h0);
    check("rst_wr_en", 32'(mem_write_enable), 32'h0);
    check("rst_rd_addr", mem_read_address, 32'h0);
    check("rst_wr_addr", mem_write_address, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // T2: load
    set_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
    serve(0, 1'b0, g);
    // T3: partial store read-modify-write
    set_req(1, 1'b1, 32'h8000_0020, 32'h0000_AB00, 4'b0010);
    serve(0, 1'b0, g);
    check("t3_word", dut_mem[8], 32'h1122_AB44);
    // T6: full store with write exception, response held while r1 waits
    mem_write_exception = 1'b1;
    set_req(0, 1'b1, 32'h8000_0030, 32'hCAFE_F00D, 4'hF);
    set_req(1, 1'b0, 32'h8000_0004, 32'h0, 4'h0);
    serve(5, 1'b1, g);
    mem_write_exception = 1'b0;
    serve(0, 1'b0, g);
    check("t6_r1_next", 32'(g), 32'h1);
    // T5: misaligned load
    set_req(0, 1'b0, 32'h8000_0002, 32'h0, 4'hF);
    serve(0, 1'b0, g);

    // T1: reset while in WRITE aborts the store
    set_req(1, 1'b1, 32'h8000_0008, 32'h5500_0000, 4'b1000);
    @(negedge CLK);
    check("t1_grant", 32'(req_ready), 32'h2);
    @(posedge CLK); #1;
    p_valid[1] = 1'b0; drive();
    @(negedge CLK);
    @(negedge CLK);
    check("t1_in_write", 32'(mem_write_enable), 32'h1);
    wc = wr_count;
    #1 RESET = 1'b1;
    #1 check("t1_wr_en_off", 32'(mem_write_enable), 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    rr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("t1_no_rsp", 32'(rsp_valid), 32'h0);
      check("t1_no_ready", 32'(req_ready), 32'h0);
    end
    check("t1_no_write", 32'(wr_count - wc), 32'h0);
    check("t1_mem_kept", dut_mem[2], ref_mem[2]);
    @(posedge CLK); #1;

    // T4: both requesters continuously, immediate ack
    prev_g = 1;
    for (int i = 0; i < 6; i++) begin
      if (!p_valid[0]) set_req(0, 1'b0, rand_addr() & ~32'h3, 32'h0, 4'hF);
      if (!p_valid[1]) set_req(1, 1'b0, rand_addr() & ~32'h3, 32'h0, 4'hF);
      serve(0, 1'b0, g);
      check("t4_alternate", 32'(g), 32'(1 - prev_g));
      prev_g = g;
    end

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!p_valid[r] && $urandom_range(0, 1) == 1)
          set_req(r, 1'($urandom_range(0, 1)), rand_addr(), $urandom, rand_be());
        else if (p_valid[r] && $urandom_range(0, 7) == 0) begin
          p_valid[r] = 1'b0; drive();
        end
      end
      mem_read_exception  = ($urandom_range(0, 9) == 0);
      mem_write_exception = ($urandom_range(0, 9) == 0);
      serve($urandom_range(0, 2), 1'($urandom_range(0, 1)), g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
